// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one bit pair per clock through a single full adder, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the operation into a - b.
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_sr, b_sr, sum_r, sum_shift;
  logic [CNT_W-1:0]   cnt;
  logic               carry, cout_r;
  logic               fa_sum, fa_carry;
  logic               accept, last_step;
  logic [WIDTH-1:0]   op_b;
  logic               op_cin;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Subtraction is a + ~b + 1; the carry-in is forced rather than taken from cin.
  always_comb begin
    op_b   = b;
    op_cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      op_b   = ~b;
      op_cin = 1'b1;
    end
`endif
  end

  // Written as shift-then-insert so WIDTH=1 needs no special slice.
  always_comb begin
    sum_shift            = sum_r >> 1;
    sum_shift[WIDTH-1]   = fa_sum;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output is defaulted before the case so no path leaves a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        last_step = (cnt == CNT_W'(WIDTH - 1));
        if (last_step) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= op_b;
      carry <= op_cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum_r <= sum_shift;
      carry <= fa_carry;
      cnt   <= cnt + CNT_W'(1);
      if (last_step) cout_r <= fa_carry;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    start(av, bv, cv);
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL %s_latency got=%0d exp=8", name, n); end
    checks++; if (sum !== exp_sum) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, sum, exp_sum); end
    checks++; if (cout !== exp_cout) begin errors++; $display("FAIL %s_cout got=%b exp=%b", name, cout, exp_cout); end
    release_result();
  endtask

  task automatic test_basic();
    test_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    test_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
  endtask

  task automatic test_backpressure();
    int n;
    // 0xF0 + 0x44 + 1 = 0x135
    start(8'hF0, 8'h44, 1'b1);
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL bp_latency got=%0d exp=8", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      checks++; if (sum !== 8'h35 || cout !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got=%b_%h exp=1_35", i, cout, sum); end
      in_valid = (i == 2);
      a = 8'hAA; b = 8'h55;
      tick();
    end
    in_valid = 1'b0;
    release_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle got=ov%b ir%b busy%b exp=ov0 ir1 busy0", out_valid, in_ready, busy); end
    checks++; if (sum !== 8'h35 || cout !== 1'b1) begin errors++; $display("FAIL bp_idle_hold got=%b_%h exp=1_35", cout, sum); end
  endtask

  task automatic test_reset_mid_run();
    start(8'hFF, 8'h00, 1'b0);
    tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL abort_cout got=%b exp=0", cout); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_state got=busy%b ir%b exp=busy0 ir1", busy, in_ready); end
    tick();
    rst = 1'b0;
    tick();
    test_add("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc_t[2];
    logic [8:0] res[2];
    int n_acc = 0;
    int n_res = 0;
    int cyc = 0;
    a = 8'h10; b = 8'h20; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_res < 2 && cyc < 60) begin
      if (out_valid) begin res[n_res] = {cout, sum}; n_res++; end
      if (in_valid && in_ready && n_acc < 2) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        tick(); cyc++;
        if (n_acc == 1) begin a = 8'h80; b = 8'h80; end
        else in_valid = 1'b0;
      end else begin
        tick(); cyc++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (n_acc !== 2 || n_res !== 2) begin errors++; $display("FAIL b2b_count got=acc%0d res%0d exp=acc2 res2", n_acc, n_res); end
    else begin
      checks++; if (acc_t[1] - acc_t[0] !== 10) begin errors++; $display("FAIL b2b_spacing got=%0d exp=10", acc_t[1] - acc_t[0]); end
      checks++; if (res[0] !== 9'h030) begin errors++; $display("FAIL b2b_res0 got=%h exp=030", res[0]); end
      checks++; if (res[1] !== 9'h100) begin errors++; $display("FAIL b2b_res1 got=%h exp=100", res[1]); end
    end
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=busy%b ir%b exp=busy0 ir1", busy, in_ready); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    sub = 1'b1;
    test_add("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    test_add("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
